plic_gateway: RTL

// - Claim/complete gateway on the consumer side of PLIC interrupt detection.
// - Takes per-source detected interrupt lines and keeps a 3-state lifecycle per source: IDLE, PENDING, IN_SERVICE.
// - Serves hart claim/complete transactions, so a source cannot re-pend until its handler completes.
// - Drives pending_o to the priority/arbitration logic and in_service_o to status registers.

---
 rtl/plic_gateway.sv | 139 +++++++++++++
 1 files changed

// File: rtl/plic_gateway.sv
// Claim/complete gateway: per-source IDLE/PENDING/IN_SERVICE lifecycle between detection and arbitration.
// Optional edge-triggered sources with saturating re-pend counters under macro PLIC_EDGE_TRIG_EN.
//
// state      | meaning
// IDLE       | no request outstanding
// PENDING    | request waiting for a hart claim
// IN_SERVICE | claimed, waiting for complete; cannot re-pend until then
module plic_gateway #(
    parameter int NUM_IRQ = 48,
    parameter int ID_W    = $clog2(NUM_IRQ + 1)
`ifdef PLIC_EDGE_TRIG_EN
    , parameter int EDGE_CNT_W = 2
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] enable_i,
    input  logic               claim_vld_i,
    input  logic [ID_W-1:0]    claim_id_i,
    input  logic               complete_vld_i,
    input  logic [ID_W-1:0]    complete_id_i,
`ifdef PLIC_EDGE_TRIG_EN
    input  logic [NUM_IRQ-1:0] edge_type_i,
`endif
    output logic [NUM_IRQ-1:0] pending_o,
    output logic [NUM_IRQ-1:0] in_service_o,
    output logic               claim_err_o,
    output logic               complete_err_o
);

    // Bit 0 marks PENDING and bit 1 marks IN_SERVICE, so outputs come straight from flops.
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PENDING    = 2'b01,
        IN_SERVICE = 2'b10
    } state_t;

    state_t state_q [NUM_IRQ];
    state_t state_d [NUM_IRQ];

    logic [NUM_IRQ-1:0] claim_hit;
    logic [NUM_IRQ-1:0] complete_hit;
    logic [NUM_IRQ-1:0] trig;
    logic [NUM_IRQ-1:0] requeue;
    logic               claim_ok;
    logic               complete_ok;
    logic               claim_err_q;
    logic               complete_err_q;

`ifdef PLIC_EDGE_TRIG_EN
    logic [NUM_IRQ-1:0]    irq_prev_q;
    logic [EDGE_CNT_W-1:0] cnt_q [NUM_IRQ];
    logic [EDGE_CNT_W-1:0] cnt_d [NUM_IRQ];
`endif

    always_comb begin
        state_d      = state_q;
        claim_hit    = '0;
        complete_hit = '0;
        trig         = irq_i;
        requeue      = '0;
        claim_ok     = 1'b0;
        complete_ok  = 1'b0;
`ifdef PLIC_EDGE_TRIG_EN
        cnt_d = cnt_q;
`endif
        for (int k = 0; k < NUM_IRQ; k++) begin
            claim_hit[k]    = claim_vld_i    && (claim_id_i    == ID_W'(k + 1));
            complete_hit[k] = complete_vld_i && (complete_id_i == ID_W'(k + 1));
`ifdef PLIC_EDGE_TRIG_EN
            if (edge_type_i[k]) begin
                trig[k]    = irq_i[k] & ~irq_prev_q[k];
                requeue[k] = (cnt_q[k] != '0);
            end
            // Pending edges are consumed by a complete and refilled by new triggers in the same cycle.
            if (!enable_i[k] || !edge_type_i[k]) begin
                cnt_d[k] = '0;
            end else begin
                if (state_q[k] == IN_SERVICE && complete_hit[k] && cnt_q[k] != '0)
                    cnt_d[k] = cnt_q[k] - EDGE_CNT_W'(1);
                if (trig[k] && state_q[k] != IDLE && cnt_d[k] != '1)
                    cnt_d[k] = cnt_d[k] + EDGE_CNT_W'(1);
            end
`endif
            case (state_q[k])
                IDLE: begin
                    if (trig[k] && enable_i[k]) state_d[k] = PENDING;
                end
                PENDING: begin
                    if (claim_hit[k]) begin
                        state_d[k] = IN_SERVICE;
                        claim_ok   = 1'b1;
                    end else if (!enable_i[k]) begin
                        state_d[k] = IDLE;
                    end
                end
                IN_SERVICE: begin
                    if (complete_hit[k]) begin
                        state_d[k]  = requeue[k] ? PENDING : IDLE;
                        complete_ok = 1'b1;
                    end
                end
                default: state_d[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= '{default: IDLE};
            claim_err_q    <= 1'b0;
            complete_err_q <= 1'b0;
`ifdef PLIC_EDGE_TRIG_EN
            irq_prev_q     <= '0;
            cnt_q          <= '{default: '0};
`endif
        end else begin
            state_q        <= state_d;
            claim_err_q    <= claim_vld_i    && (claim_id_i    != '0) && !claim_ok;
            complete_err_q <= complete_vld_i && (complete_id_i != '0) && !complete_ok;
`ifdef PLIC_EDGE_TRIG_EN
            irq_prev_q     <= irq_i;
            cnt_q          <= cnt_d;
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_IRQ; k++) begin
            pending_o[k]    = state_q[k][0];
            in_service_o[k] = state_q[k][1];
        end
    end

    assign claim_err_o    = claim_err_q;
    assign complete_err_o = complete_err_q;

endmodule
